mode4_sum_feeder: RTL and testbench

Upstream feeder and sequencer for the 4-lane mode-4 FP adder tree in the softmax datapath. It accepts one beat of four FP exponent results per handshake and registers them onto the tree inputs. It generates the tree's three stage-run enables as a valid pipeline and zero-pads unused lanes of a partial tail beat. It clears the tree accumulator at the start of a vector and pulses done when the tree output holds the complete vector sum.

---
 rtl/mode4_sum_feeder.sv | 131 +++++++++++++
 tb/tb_mode4_sum_feeder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mode4_sum_feeder.sv
// Feeder/sequencer for the 4-lane mode-4 FP adder tree: registers beats onto
// the tree inputs, pipelines the stage-run enables and signals the final sum.
module mode4_sum_feeder #(
   parameter int DATAWIDTH = 16,
   parameter int LENWIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [LENWIDTH-1:0]  vec_len,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATAWIDTH-1:0] in_data0,
   input  logic [DATAWIDTH-1:0] in_data1,
   input  logic [DATAWIDTH-1:0] in_data2,
   input  logic [DATAWIDTH-1:0] in_data3,
   output logic [DATAWIDTH-1:0] tree_inp0,
   output logic [DATAWIDTH-1:0] tree_inp1,
   output logic [DATAWIDTH-1:0] tree_inp2,
   output logic [DATAWIDTH-1:0] tree_inp3,
   output logic                 mode4_stage2_run,
   output logic                 mode4_stage1_run,
   output logic                 mode4_stage0_run,
   output logic                 acc_clear,
   output logic                 busy,
   output logic                 sum_done
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t               state;
   state_t               state_nx;
   logic [LENWIDTH-2:0]  beats_left;
   logic [LENWIDTH-2:0]  beats_init;
   logic [LENWIDTH:0]    len_ext;
   logic [1:0]           tail;
   logic                 s2;
   logic                 s1;
   logic                 s0;
   logic                 accept;
   logic                 last;
   logic                 zero1;
   logic                 zero2;
   logic                 zero3;

   // One extra bit keeps the +3 of the ceiling from overflowing.
   assign len_ext    = {1'b0, vec_len} + (LENWIDTH+1)'(3);
   assign beats_init = len_ext[LENWIDTH:2];

   assign accept = in_valid & in_ready;
   assign last   = (beats_left == (LENWIDTH-1)'(1));
   assign zero1  = last && (tail == 2'd1);
   assign zero2  = last && ((tail == 2'd1) || (tail == 2'd2));
   assign zero3  = last && (tail != 2'd0);

   assign mode4_stage2_run = s2;
   assign mode4_stage1_run = s1;
   assign mode4_stage0_run = s0;

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      acc_clear = 1'b0;
      sum_done  = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (start)
               state_nx = CLEAR;
         end
         CLEAR: begin
            acc_clear = 1'b1;
            state_nx  = (beats_left != '0) ? RUN : DONE;
         end
         RUN: begin
            in_ready = (beats_left != '0);
            if (accept && last)
               state_nx = DRAIN;
         end
         DRAIN: begin
            // s0 retires into the accumulator on this edge.
            if (!s2 && !s1)
               state_nx = DONE;
         end
         DONE: begin
            sum_done = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         beats_left <= '0;
         tail       <= '0;
         s2         <= 1'b0;
         s1         <= 1'b0;
         s0         <= 1'b0;
         tree_inp0  <= '0;
         tree_inp1  <= '0;
         tree_inp2  <= '0;
         tree_inp3  <= '0;
      end else begin
         state <= state_nx;
         s2    <= accept;
         s1    <= s2;
         s0    <= s1;
         if (state == IDLE && start) begin
            beats_left <= beats_init;
            tail       <= vec_len[1:0];
         end else if (accept) begin
            beats_left <= beats_left - (LENWIDTH-1)'(1);
         end
         if (accept) begin
            tree_inp0 <= in_data0;
            tree_inp1 <= zero1 ? '0 : in_data1;
            tree_inp2 <= zero2 ? '0 : in_data2;
            tree_inp3 <= zero3 ? '0 : in_data3;
         end
      end
   end

endmodule

// File: tb/tb_mode4_sum_feeder.sv
// Directed bench for mode4_sum_feeder with a behavioural adder tree driven
// by the DUT's stage enables.
module tb_mode4_sum_feeder;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] vec_len;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data0, in_data1, in_data2, in_data3;
   logic [15:0] tree_inp0, tree_inp1, tree_inp2, tree_inp3;
   logic        mode4_stage2_run;
   logic        mode4_stage1_run;
   logic        mode4_stage0_run;
   logic        acc_clear;
   logic        busy;
   logic        sum_done;

   int total = 0;
   int bad   = 0;

   real p0, p1, q, acc;
   int  cnt2, cnt1, cnt0, cnt_rdy;

   mode4_sum_feeder #(.DATAWIDTH(16), .LENWIDTH(16)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .vec_len          (vec_len),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_data0         (in_data0),
      .in_data1         (in_data1),
      .in_data2         (in_data2),
      .in_data3         (in_data3),
      .tree_inp0        (tree_inp0),
      .tree_inp1        (tree_inp1),
      .tree_inp2        (tree_inp2),
      .tree_inp3        (tree_inp3),
      .mode4_stage2_run (mode4_stage2_run),
      .mode4_stage1_run (mode4_stage1_run),
      .mode4_stage0_run (mode4_stage0_run),
      .acc_clear        (acc_clear),
      .busy             (busy),
      .sum_done         (sum_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic real f16(input logic [15:0] h);
      real r;
      int  e;
      e = int'(h[14:10]);
      if (e == 0) return 0.0;
      r = 1.0 + real'(h[9:0]) / 1024.0;
      for (int i = 15; i < e; i++) r = r * 2.0;
      for (int i = e; i < 15; i++) r = r / 2.0;
      return h[15] ? -r : r;
   endfunction

   // Model of the tree: two pair adders, one combiner, one accumulator.
   always @(posedge clk) begin
      if (reset || acc_clear) begin
         p0 <= 0.0; p1 <= 0.0; q <= 0.0; acc <= 0.0;
         cnt2 <= 0; cnt1 <= 0; cnt0 <= 0; cnt_rdy <= 0;
      end else begin
         if (mode4_stage2_run) begin
            p0 <= f16(tree_inp0) + f16(tree_inp1);
            p1 <= f16(tree_inp2) + f16(tree_inp3);
         end
         if (mode4_stage1_run) q <= p0 + p1;
         if (mode4_stage0_run) acc <= acc + q;
         cnt2    <= cnt2 + int'(mode4_stage2_run);
         cnt1    <= cnt1 + int'(mode4_stage1_run);
         cnt0    <= cnt0 + int'(mode4_stage0_run);
         cnt_rdy <= cnt_rdy + int'(in_ready);
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input int len, input logic [15:0] val,
                          input logic [15:0] junk, input bit gaps,
                          input int exp_sum);
      int  beats, t, i, guard, k;
      bit  acc_now, seen, lastb;
      beats = (len + 3) / 4;
      t     = len % 4;
      start   = 1'b1;
      vec_len = 16'(len);
      tick;
      start = 1'b0;
      check("clear_pulse", 32'(acc_clear), 32'd1);
      i = 0;
      guard = 0;
      while (i < beats && guard < 2 * beats + 20) begin
         lastb    = (i == beats - 1) && (t != 0);
         in_valid = gaps ? (guard % 2 == 0) : 1'b1;
         start    = gaps && (guard == 3);
         vec_len  = 16'd40;
         in_data0 = val;
         in_data1 = (lastb && t <= 1) ? junk : val;
         in_data2 = (lastb && t <= 2) ? junk : val;
         in_data3 = lastb ? junk : val;
         acc_now  = in_valid && in_ready;
         tick;
         if (acc_now) i++;
         guard++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      check("beats_acc", 32'(i), 32'(beats));
      if (t != 0) check("tail_lane3", 32'(tree_inp3), 32'd0);
      k = 0;
      seen = 1'b0;
      while (k < 20 && !seen) begin
         tick;
         k++;
         if (sum_done) seen = 1'b1;
      end
      check("done_seen", 32'(seen), 32'd1);
      check("done_lat", 32'(k), (beats == 0) ? 32'd1 : 32'd3);
      check("sum", 32'($rtoi(acc)), 32'(exp_sum));
      check("cnt_s2", 32'(cnt2), 32'(beats));
      check("cnt_s1", 32'(cnt1), 32'(beats));
      check("cnt_s0", 32'(cnt0), 32'(beats));
      if (!gaps) check("rdy_cycles", 32'(cnt_rdy), 32'(beats));
      tick;
      check("done_pulse", 32'(sum_done), 32'd0);
      check("idle", 32'(busy), 32'd0);
   endtask

   initial begin
      int nd;
      reset    = 1'b1;
      start    = 1'b0;
      vec_len  = '0;
      in_valid = 1'b0;
      in_data0 = '0; in_data1 = '0; in_data2 = '0; in_data3 = '0;
      tick;
      tick;
      check("rst_outs",
            {tree_inp0, tree_inp3, 8'h0, in_ready, mode4_stage2_run,
             mode4_stage1_run, mode4_stage0_run, acc_clear, busy, sum_done,
             1'b0},
            32'd0);
      reset = 1'b0;
      tick;

      run_vec(8, 16'h3C00, 16'h3C00, 1'b0, 8);
      run_vec(6, 16'h3C00, 16'h7BFF, 1'b0, 6);
      run_vec(0, 16'h3C00, 16'h3C00, 1'b0, 0);
      run_vec(12, 16'h3C00, 16'h3C00, 1'b1, 12);
      run_vec(7, 16'h4000, 16'h7BFF, 1'b0, 14);

      start   = 1'b1;
      vec_len = 16'd12;
      tick;
      start    = 1'b0;
      in_valid = 1'b1;
      in_data0 = 16'h3C00; in_data1 = 16'h3C00;
      in_data2 = 16'h3C00; in_data3 = 16'h3C00;
      tick;
      tick;
      reset    = 1'b1;
      in_valid = 1'b0;
      tick;
      check("abort_outs",
            {tree_inp0, tree_inp2, in_ready, mode4_stage2_run, busy,
             sum_done},
            36'd0);
      reset = 1'b0;
      nd = 0;
      for (int c = 0; c < 8; c++) begin
         tick;
         nd += int'(sum_done);
      end
      check("abort_nodone", 32'(nd), 32'd0);
      run_vec(4, 16'h3C00, 16'h3C00, 1'b0, 4);

      run_vec(16, 16'h3C00, 16'h3C00, 1'b0, 16);
      run_vec(4, 16'h4000, 16'h4000, 1'b0, 8);

      run_vec(65535, 16'h0000, 16'h7BFF, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
